// File: rtl/ddr3_pattern_test_sm.sv
// DDR3 memory-test sequencer: optional power-down exercise, pattern write pass,
// read-back compare, error/pass reporting and optional soak looping.
module ddr3_pattern_test_sm #(
  parameter int              ADDR_W      = 26,
  parameter int              DATA_W      = 64,
  parameter int              NUM_WORDS   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 26'h0001400,
  parameter int              ADDR_STRIDE = 1,
  parameter int              PATTERN     = 0,
  parameter logic [63:0]     SEED        = 64'h0123456789ABCDEF,
  parameter bit              DO_PDOWN    = 1'b1,
  parameter bit              LOOP        = 1'b0,
  parameter int              RD_TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cmd_rdy,
  input  logic                datain_rdy,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                read_data_valid,
  input  logic                wl_err,
  output logic                cmd_valid,
  output logic [3:0]          cmd,
  output logic [4:0]          cmd_burst_cnt,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   write_data,
  output logic [DATA_W/8-1:0] data_mask,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [15:0]         loop_count
);

  localparam logic [3:0]  CMD_NADA       = 4'b0000;
  localparam logic [3:0]  CMD_READ       = 4'b0001;
  localparam logic [3:0]  CMD_WRITE      = 4'b0010;
  localparam logic [3:0]  CMD_PDOWN_ENT  = 4'b0101;
  localparam logic [3:0]  CMD_PDOWN_EXIT = 4'b1011;
  localparam logic [15:0] LAST_IDX       = 16'(NUM_WORDS - 1);
  localparam logic [31:0] TO_LAST        = 32'(RD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PDOWN_ENT, S_PDOWN_EXIT, S_WRITE, S_WDATA, S_READ, S_RWAIT, S_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] idx);
    return BASE_ADDR + ADDR_W'(32'(idx) * 32'(ADDR_STRIDE));
  endfunction

  function automatic logic [DATA_W-1:0] pattern_of(input logic [15:0] idx);
    logic [DATA_W-1:0] rep;
    rep = '0;
    case (PATTERN)
      1: return DATA_W'(1) << (int'(idx) % DATA_W);
      2: begin
        for (int k = 0; k < DATA_W; k += ADDR_W)
          rep |= DATA_W'(addr_of(idx)) << k;
        return DATA_W'(SEED) ^ rep;
      end
      default: return DATA_W'(SEED) + DATA_W'(idx);
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t              state, state_n;
  logic                cmd_valid_n;
  logic [3:0]          cmd_n;
  logic [ADDR_W-1:0]   addr_n, first_err_addr_n;
  logic [DATA_W-1:0]   write_data_n;
  logic [15:0]         err_count_n, loop_count_n, idx, idx_n;
  logic [31:0]         to_ctr, to_ctr_n;
  logic                timeout_flag, timeout_flag_n, wl_sticky, wl_sticky_n;
  logic                issue, word_done, word_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd_valid      <= 1'b0;
      cmd            <= CMD_NADA;
      addr           <= '0;
      write_data     <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      loop_count     <= '0;
      idx            <= '0;
      to_ctr         <= '0;
      timeout_flag   <= 1'b0;
      wl_sticky      <= 1'b0;
    end else begin
      state          <= state_n;
      cmd_valid      <= cmd_valid_n;
      cmd            <= cmd_n;
      addr           <= addr_n;
      write_data     <= write_data_n;
      err_count      <= err_count_n;
      first_err_addr <= first_err_addr_n;
      loop_count     <= loop_count_n;
      idx            <= idx_n;
      to_ctr         <= to_ctr_n;
      timeout_flag   <= timeout_flag_n;
      wl_sticky      <= wl_sticky_n;
    end
  end

  always_comb begin
    state_n          = state;
    cmd_valid_n      = 1'b0;
    cmd_n            = CMD_NADA;
    addr_n           = addr;
    write_data_n     = write_data;
    err_count_n      = err_count;
    first_err_addr_n = first_err_addr;
    loop_count_n     = loop_count;
    idx_n            = idx;
    to_ctr_n         = to_ctr;
    timeout_flag_n   = timeout_flag;
    wl_sticky_n      = wl_sticky;
    word_done        = 1'b0;
    word_err         = 1'b0;
    // A command is only launched into a free slot, so every strobe lasts one cycle.
    issue            = cmd_rdy && !cmd_valid;

    if (busy && wl_err) begin
      wl_sticky_n = 1'b1;
      state_n     = S_DONE;
    end else begin
      case (state)
        S_IDLE:       if (start) state_n = S_INIT;
        S_INIT:       if (cmd_rdy) state_n = DO_PDOWN ? S_PDOWN_ENT : S_WRITE;
        S_PDOWN_ENT: if (issue) begin
          cmd_valid_n = 1'b1;
          cmd_n       = CMD_PDOWN_ENT;
          state_n     = S_PDOWN_EXIT;
        end
        S_PDOWN_EXIT: if (issue) begin
          cmd_valid_n = 1'b1;
          cmd_n       = CMD_PDOWN_EXIT;
          state_n     = S_WRITE;
        end
        S_WRITE: if (issue) begin
          cmd_valid_n  = 1'b1;
          cmd_n        = CMD_WRITE;
          addr_n       = addr_of(idx);
          write_data_n = pattern_of(idx);
          state_n      = S_WDATA;
        end
        S_WDATA: if (datain_rdy) begin
          idx_n   = (idx == LAST_IDX) ? 16'd0 : idx + 16'd1;
          state_n = (idx == LAST_IDX) ? S_READ : S_WRITE;
        end
        S_READ: if (issue) begin
          cmd_valid_n = 1'b1;
          cmd_n       = CMD_READ;
          addr_n      = addr_of(idx);
          to_ctr_n    = '0;
          state_n     = S_RWAIT;
        end
        S_RWAIT: begin
          if (read_data_valid) begin
            word_done = 1'b1;
            word_err  = (read_data != pattern_of(idx));
          end else if (to_ctr == TO_LAST) begin
            word_done      = 1'b1;
            word_err       = 1'b1;
            timeout_flag_n = 1'b1;
          end else begin
            to_ctr_n = to_ctr + 32'd1;
          end
          if (word_err) begin
            err_count_n = sat_inc(err_count);
            if (err_count == '0) first_err_addr_n = addr_of(idx);
          end
          if (word_done) begin
            if (idx == LAST_IDX) begin
              idx_n        = '0;
              loop_count_n = loop_count + 16'd1;
              state_n      = LOOP ? S_WRITE : S_DONE;
            end else begin
              idx_n   = idx + 16'd1;
              state_n = S_READ;
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

  assign cmd_burst_cnt = 5'b00001;
  assign data_mask     = '0;
  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign pass          = done && (err_count == '0) && !timeout_flag && !wl_sticky;

endmodule

// File: tb/tb_ddr3_pattern_test_sm.sv
// Bench for ddr3_pattern_test_sm: controller model, command scoreboard, directed scenarios
// on a normal instance and on a wrapping-address looping instance.
module tb_ddr3_pattern_test_sm;

  localparam logic [3:0] C_READ = 4'b0001, C_WRITE = 4'b0010;
  localparam logic [3:0] C_PDE  = 4'b0101, C_PDX   = 4'b1011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel, start, cmd_rdy, datain_rdy, read_data_valid, wl_err;
  logic [63:0] read_data;
  logic rst_a, rst_b;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic a_cv, b_cv, a_busy, b_busy, a_done, b_done, a_pass, b_pass;
  logic [3:0] a_cmd, b_cmd;
  logic [4:0] a_bc, b_bc;
  logic [25:0] a_addr, b_addr, a_fea, b_fea;
  logic [63:0] a_wd, b_wd;
  logic [7:0] a_dm, b_dm;
  logic [15:0] a_ec, b_ec, a_lc, b_lc;

  ddr3_pattern_test_sm #(.NUM_WORDS(4), .PATTERN(0), .DO_PDOWN(1'b1), .LOOP(1'b0),
                         .RD_TIMEOUT(15)) dut_a (
    .clk(clk), .rst(rst_a), .start(start), .cmd_rdy(cmd_rdy), .datain_rdy(datain_rdy),
    .read_data(read_data), .read_data_valid(read_data_valid), .wl_err(wl_err),
    .cmd_valid(a_cv), .cmd(a_cmd), .cmd_burst_cnt(a_bc), .addr(a_addr), .write_data(a_wd),
    .data_mask(a_dm), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_ec),
    .first_err_addr(a_fea), .loop_count(a_lc));

  ddr3_pattern_test_sm #(.NUM_WORDS(4), .BASE_ADDR(26'h3FFFFFE), .PATTERN(1), .DO_PDOWN(1'b0),
                         .LOOP(1'b1), .RD_TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst_b), .start(start), .cmd_rdy(cmd_rdy), .datain_rdy(datain_rdy),
    .read_data(read_data), .read_data_valid(read_data_valid), .wl_err(wl_err),
    .cmd_valid(b_cv), .cmd(b_cmd), .cmd_burst_cnt(b_bc), .addr(b_addr), .write_data(b_wd),
    .data_mask(b_dm), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_ec),
    .first_err_addr(b_fea), .loop_count(b_lc));

  logic cmd_valid, busy, done, pass;
  logic [3:0] cmd;
  logic [4:0] burst;
  logic [25:0] addr, first_err_addr;
  logic [63:0] write_data;
  logic [7:0] data_mask;
  logic [15:0] err_count, loop_count;
  assign cmd_valid      = sel ? b_cv   : a_cv;
  assign cmd            = sel ? b_cmd  : a_cmd;
  assign burst          = sel ? b_bc   : a_bc;
  assign addr           = sel ? b_addr : a_addr;
  assign write_data     = sel ? b_wd   : a_wd;
  assign data_mask      = sel ? b_dm   : a_dm;
  assign busy           = sel ? b_busy : a_busy;
  assign done           = sel ? b_done : a_done;
  assign pass           = sel ? b_pass : a_pass;
  assign err_count      = sel ? b_ec   : a_ec;
  assign first_err_addr = sel ? b_fea  : a_fea;
  assign loop_count     = sel ? b_lc   : a_lc;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [25:0] a;
    logic [63:0] d;
    bit          chk_a;
    bit          chk_d;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic [3:0] c, input logic [25:0] a, input logic [63:0] d,
                      input bit ca, input bit cd);
    exp_t e;
    e.c = c; e.a = a; e.d = d; e.chk_a = ca; e.chk_d = cd;
    exp_q.push_back(e);
  endtask

  // Hand-computed vectors
  logic [25:0] a_addrs[4] = '{26'h0001400, 26'h0001401, 26'h0001402, 26'h0001403};
  logic [63:0] a_datas[4] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDF0,
                              64'h0123456789ABCDF1, 64'h0123456789ABCDF2};
  logic [25:0] b_addrs[4] = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0000000, 26'h0000001};
  logic [63:0] b_datas[4] = '{64'h1, 64'h2, 64'h4, 64'h8};

  // Controller model
  logic [63:0] mem [logic [25:0]];
  bit rand_rdy = 0, corrupt_en = 0, drop_en = 0, rdy_prev = 0;
  logic [25:0] corrupt_addr = '0, drop_addr = '0;

  initial begin
    cmd_rdy = 1'b0; datain_rdy = 1'b1; read_data_valid = 1'b0; read_data = '0;
    forever begin
      @(posedge clk); #1;
      rdy_prev = cmd_rdy;
      read_data_valid = 1'b0;
      if (cmd_valid && cmd == C_WRITE) mem[addr] = write_data;
      if (cmd_valid && cmd == C_READ && !(drop_en && addr == drop_addr)) begin
        read_data_valid = 1'b1;
        read_data = mem.exists(addr) ? mem[addr] : 64'h0;
        if (corrupt_en && addr == corrupt_addr) read_data[0] = ~read_data[0];
      end
      cmd_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Command monitor / scoreboard
  int rd_cyc[16];
  int rd_n = 0;
  bit last_cv = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        chk("cv_single_cycle", 64'(last_cv), 64'(0));
        chk("cv_after_rdy", 64'(rdy_prev), 64'(1));
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 64'(cmd), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("cmd", 64'(cmd), 64'(e.c));
          if (e.chk_a) chk("addr", 64'(addr), 64'(e.a));
          if (e.chk_d) chk("write_data", write_data, e.d);
        end
        if (cmd == C_READ && rd_n < 16) begin
          rd_cyc[rd_n] = cyc;
          rd_n++;
        end
      end
      last_cv = cmd_valid;
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; wl_err = 1'b0;
    corrupt_en = 0; drop_en = 0; rand_rdy = 0;
    repeat (3) @(negedge clk);
    mem.delete();
    exp_q.delete();
    rd_n = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_pass_a(input int nwrites, input bit reads);
    push(C_PDE, '0, '0, 0, 0);
    push(C_PDX, '0, '0, 0, 0);
    for (int k = 0; k < nwrites; k++) push(C_WRITE, a_addrs[k], a_datas[k], 1, 1);
    if (reads) for (int k = 0; k < 4; k++) push(C_READ, a_addrs[k], '0, 1, 0);
  endtask

  task automatic check_result(input string t, input bit p, input int ec, input bit cf,
                              input logic [25:0] fea);
    chk({t, "_done"}, 64'(done), 64'(1));
    chk({t, "_busy"}, 64'(busy), 64'(0));
    chk({t, "_pass"}, 64'(pass), 64'(p));
    chk({t, "_err_count"}, 64'(err_count), 64'(ec));
    if (cf) chk({t, "_first_err_addr"}, 64'(first_err_addr), 64'(fea));
    chk({t, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n, nwr, gap;
    sel = 1'b0;
    do_reset();

    // Reset state
    chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst_cmd", 64'(cmd), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_write_data", write_data, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_first_err_addr", 64'(first_err_addr), 64'(0));
    chk("rst_loop_count", 64'(loop_count), 64'(0));
    chk("burst_cnt", 64'(burst), 64'(1));
    chk("data_mask", 64'(data_mask), 64'(0));

    // Ideal controller, clean pass
    push_pass_a(4, 1);
    pulse_start();
    chk("t1_busy_after_start", 64'(busy), 64'(1));
    wait_done();
    check_result("t1", 1, 0, 0, '0);
    chk("t1_loop_count", 64'(loop_count), 64'(1));
    pulse_start();
    chk("t1_start_ignored_in_done", 64'(done), 64'(1));

    // Corrupted bit0 on word 2
    do_reset();
    corrupt_en = 1; corrupt_addr = 26'h0001402;
    push_pass_a(4, 1);
    pulse_start();
    wait_done();
    check_result("t2", 0, 1, 1, 26'h0001402);

    // Dropped read return on word 1
    do_reset();
    drop_en = 1; drop_addr = 26'h0001401;
    push_pass_a(4, 1);
    pulse_start();
    wait_done();
    check_result("t3", 0, 1, 1, 26'h0001401);
    gap = rd_cyc[2] - rd_cyc[1];
    chk("t3_timeout_gap_in_range", 64'(gap >= 16 && gap <= 17), 64'(1));

    // wl_err during second write
    do_reset();
    push_pass_a(2, 0);
    pulse_start();
    n = 0; nwr = 0;
    while (nwr < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (cmd_valid && cmd == C_WRITE) nwr++;
    end
    chk("t4_second_write_seen", 64'(nwr), 64'(2));
    wl_err = 1'b1;
    @(negedge clk);
    wl_err = 1'b0;
    repeat (20) @(negedge clk);
    check_result("t4", 0, 0, 0, '0);

    // Wrapping addresses, walking-one data, loop mode, random cmd_rdy, reset mid-write
    sel = 1'b1;
    do_reset();
    rand_rdy = 1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) push(C_WRITE, b_addrs[k], b_datas[k], 1, 1);
      for (int k = 0; k < 4; k++) push(C_READ, b_addrs[k], '0, 1, 0);
    end
    pulse_start();
    n = 0;
    while (loop_count != 16'd2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_loop_count", 64'(loop_count), 64'(2));
    chk("t6_err_count", 64'(err_count), 64'(0));
    chk("t6_busy_looping", 64'(busy), 64'(1));
    n = 0;
    while (exp_q.size() > 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_third_pass_writes", 64'(exp_q.size() <= 6), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("t6_rst_cmd", 64'(cmd), 64'(0));
    chk("t6_rst_addr", 64'(addr), 64'(0));
    chk("t6_rst_write_data", write_data, 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_done", 64'(done), 64'(0));
    chk("t6_rst_loop_count", 64'(loop_count), 64'(0));
    chk("t6_rst_err_count", 64'(err_count), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_idle_after_rst", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
